// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared types and constants for the writeback stage
package wb_stage_pkg;
  typedef logic [31:0] word_t;

  localparam word_t      NOP_WORD_DEF = 32'h0000_0000;
  localparam logic [4:0] REG_ZERO     = 5'd0;

  typedef enum logic {
    WB_IDLE,
    WB_REDIRECT
  } wb_state_e;
endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM/WB field bundle in, GPR write port out
interface wb_stage_if;
  import wb_stage_pkg::*;

  word_t      order;
  word_t      regfile_din;
  word_t      alu_result2;
  word_t      noint_next_pc;
  logic [4:0] write_reg_num;
  logic       reg_write_enable;
  logic       hi_lo_write_enable;
  logic       hi_write_to_gpr;
  logic       lo_write_to_gpr;
  logic       circular_eret;

  logic       rf_we;
  logic [4:0] rf_waddr;
  word_t      rf_wdata;

  modport master (
    output order, regfile_din, alu_result2, noint_next_pc, write_reg_num,
           reg_write_enable, hi_lo_write_enable, hi_write_to_gpr,
           lo_write_to_gpr, circular_eret,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  order, regfile_din, alu_result2, noint_next_pc, write_reg_num,
           reg_write_enable, hi_lo_write_enable, hi_write_to_gpr,
           lo_write_to_gpr, circular_eret,
    output rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_hilo_regs.sv
// rtl/wb_hilo_regs.sv - architectural HI/LO pair and the MFHI/MFLO read mux
module wb_hilo_regs
  import wb_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_en,
  input  word_t hi_din,
  input  word_t lo_din,
  input  logic  hi_sel,
  input  logic  lo_sel,
  input  word_t gpr_din,
  output word_t hi_q,
  output word_t lo_q,
  output word_t rd_data
);
  word_t hi_d;
  word_t lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (wr_en) begin
      hi_d = hi_din;
      lo_d = lo_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Reads see the registered pair only; a same-cycle write is not bypassed.
  always_comb begin
    rd_data = gpr_din;
    if (hi_sel)      rd_data = hi_q;
    else if (lo_sel) rd_data = lo_q;
  end
endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: GPR write port, HI/LO, EPC, ERET redirect
// Retire counter present only when WB_RETIRE_CNT_EN is defined.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter word_t NOP_WORD = NOP_WORD_DEF,
  parameter int    RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  wb_stage_if.slave           wb,
  output word_t               hi_q,
  output word_t               lo_q,
  output word_t               epc_out,
  output logic                eret_redirect,
  output word_t               eret_pc,
  output logic [RETIRE_W-1:0] retire_count
);
  wb_state_e state_q, state_d;
  logic      redirect_q, redirect_d;
  word_t     eret_pc_q, eret_pc_d;
  word_t     epc_q, epc_d;
  logic      retired;
  logic      eret_take;

  assign retired   = enable && (wb.order != NOP_WORD);
  assign eret_take = enable && wb.circular_eret;

  assign wb.rf_we    = enable && wb.reg_write_enable && (wb.write_reg_num != REG_ZERO);
  assign wb.rf_waddr = wb.write_reg_num;

  wb_hilo_regs u_hilo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (enable && wb.hi_lo_write_enable),
    .hi_din  (wb.alu_result2),
    .lo_din  (wb.regfile_din),
    .hi_sel  (wb.hi_write_to_gpr),
    .lo_sel  (wb.lo_write_to_gpr),
    .gpr_din (wb.regfile_din),
    .hi_q    (hi_q),
    .lo_q    (lo_q),
    .rd_data (wb.rf_wdata)
  );

  // REDIRECT always leaves after one edge unless a fresh ERET arrives, so a
  // stalled pipe (enable=0) still sees a single-cycle pulse.
  always_comb begin
    state_d    = state_q;
    redirect_d = 1'b0;
    eret_pc_d  = eret_pc_q;
    epc_d      = retired ? wb.noint_next_pc : epc_q;
    case (state_q)
      WB_IDLE: begin
        if (eret_take) begin
          state_d    = WB_REDIRECT;
          redirect_d = 1'b1;
          eret_pc_d  = wb.noint_next_pc;
        end
      end
      WB_REDIRECT: begin
        if (eret_take) begin
          redirect_d = 1'b1;
          eret_pc_d  = wb.noint_next_pc;
        end else begin
          state_d = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WB_IDLE;
      redirect_q <= 1'b0;
      eret_pc_q  <= '0;
      epc_q      <= '0;
    end else begin
      state_q    <= state_d;
      redirect_q <= redirect_d;
      eret_pc_q  <= eret_pc_d;
      epc_q      <= epc_d;
    end
  end

  assign eret_redirect = redirect_q;
  assign eret_pc       = eret_pc_q;
  assign epc_out       = epc_q;

`ifdef WB_RETIRE_CNT_EN
  logic [RETIRE_W-1:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (retired) retire_cnt_d = retire_cnt_q + RETIRE_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) retire_cnt_q <= '0;
    else     retire_cnt_q <= retire_cnt_d;
  end

  assign retire_count = retire_cnt_q;
`else
  assign retire_count = '0;
`endif
endmodule
